// File: rtl/pipelined_nbit_adder.sv
// pipelined_nbit_adder: {cout,sum} = a + b + ci over STAGES registered ripple segments; ADDER_OVERFLOW_FLAG_EN adds signed-overflow output ovf
module pipelined_nbit_adder #(
  parameter int N = 8,
  parameter int STAGES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         out_valid,
  output logic [N-1:0] sum,
  output logic         cout
`ifdef ADDER_OVERFLOW_FLAG_EN
  ,
  output logic         ovf
`endif
);
  localparam int W = (N + STAGES - 1) / STAGES;
  logic         v_p [STAGES+1];
  logic [N-1:0] s_p [STAGES+1];
  logic         c_p [STAGES+1];
  logic [N-1:0] a_p [STAGES];
  logic [N-1:0] b_p [STAGES];
  assign v_p[0] = in_valid;
  assign s_p[0] = '0;
  assign c_p[0] = ci;
  assign a_p[0] = a;
  assign b_p[0] = b;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * W;
    localparam int HI = ((k + 1) * W > N) ? N : (k + 1) * W;
    localparam logic [N-1:0] M = (HI > LO) ? (({N{1'b1}} >> (N - HI + LO)) << LO) : '0;
    logic [N:0]   t;
    logic [N-1:0] s_n;
    logic         c_n;
    logic         v_q;
    logic [N-1:0] s_q;
    logic         c_q;
    assign t   = (N+1)'(a_p[k] & M) + (N+1)'(b_p[k] & M) + ((N+1)'(c_p[k]) << LO);
    assign s_n = s_p[k] | (N'(t) & M);
    assign c_n = (HI > LO) ? t[HI] : c_p[k];
    // Valid always advances; partial sum and carry only load on valid so bubbles hold the last result.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else begin
        v_q <= v_p[k];
        if (v_p[k]) begin
          s_q <= s_n;
          c_q <= c_n;
        end
      end
    end
    assign v_p[k+1] = v_q;
    assign s_p[k+1] = s_q;
    assign c_p[k+1] = c_q;
    if (k < STAGES - 1) begin : g_op
      logic [N-1:0] a_q;
      logic [N-1:0] b_q;
      // Operands travel with their partial result until their upper segments are consumed.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (v_p[k]) begin
          a_q <= a_p[k];
          b_q <= b_p[k];
        end
      end
      assign a_p[k+1] = a_q;
      assign b_p[k+1] = b_q;
    end
`ifdef ADDER_OVERFLOW_FLAG_EN
    else begin : g_ovf
      logic o_q;
      // Carry into the MSB is recovered as a^b^sum at bit N-1, then xored with the final carry.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) o_q <= 1'b0;
        else if (v_p[k]) o_q <= a_p[k][N-1] ^ b_p[k][N-1] ^ s_n[N-1] ^ c_n;
      end
      assign ovf = o_q;
    end
`endif
  end
  assign out_valid = v_p[STAGES];
  assign sum       = s_p[STAGES];
  assign cout      = c_p[STAGES];
endmodule

// File: tb/tb_pipelined_nbit_adder.sv
// tb_pipelined_nbit_adder: randomized scoreboard bench for pipelined_nbit_adder (ADDER_OVERFLOW_FLAG_EN also checks ovf)
module tb_pipelined_nbit_adder #(
  parameter int N = 8,
  parameter int STAGES = 4
);
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         ci = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         out_valid;
  logic         cout;
  logic [N-1:0] sum;
`ifdef ADDER_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  pipelined_nbit_adder #(.N(N), .STAGES(STAGES)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .ci(ci),
    .out_valid(out_valid),
    .sum(sum),
    .cout(cout)
`ifdef ADDER_OVERFLOW_FLAG_EN
    ,
    .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] s;
    logic         c;
    logic         o;
    int           at;
  } exp_t;

  exp_t         q[$];
  exp_t         m;
  int           cyc = 0;
  int           compared = 0;
  int           mismatched = 0;
  logic [N-1:0] hold_s = '0;
  logic         hold_c = 1'b0;
  logic         hold_o = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [N-1:0] rnd();
    int p = $urandom_range(0, 7);
    if (p == 0) return '1;
    if (p == 1) return '0;
    return N'({$urandom(), $urandom()});
  endfunction

  // Drive one slot; valid slots push the arithmetic result and its due cycle.
  task automatic send(input logic v, input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    exp_t       e;
    logic [N:0] full;
    @(negedge clk);
    in_valid = v;
    a  = v ? x : rnd();
    b  = v ? y : rnd();
    ci = v ? c : 1'($urandom());
    if (v) begin
      full = {1'b0, x} + {1'b0, y} + (N+1)'(c);
      e.s  = full[N-1:0];
      e.c  = full[N];
      e.o  = (x[N-1] == y[N-1]) && (full[N-1] != x[N-1]);
      e.at = cyc + STAGES;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < STAGES + 20 && q.size() != 0; i++) send(1'b0, '0, '0, 1'b0);
    if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  // Monitor: pops on every valid output, otherwise checks that the last result is held.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      hold_s = '0;
      hold_c = 1'b0;
      hold_o = 1'b0;
    end else if (out_valid) begin
      if (q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
      else begin
        m = q.pop_front();
        chk("sum", 64'(sum), 64'(m.s));
        chk("cout", 64'(cout), 64'(m.c));
`ifdef ADDER_OVERFLOW_FLAG_EN
        chk("ovf", 64'(ovf), 64'(m.o));
`endif
        chk("latency_cycle", 64'(cyc), 64'(m.at));
        hold_s = m.s;
        hold_c = m.c;
        hold_o = m.o;
      end
    end else begin
      chk("hold_sum", 64'(sum), 64'(hold_s));
      chk("hold_cout", 64'(cout), 64'(hold_c));
`ifdef ADDER_OVERFLOW_FLAG_EN
      chk("hold_ovf", 64'(ovf), 64'(hold_o));
`endif
    end
  end

  int xs[7] = '{0, 5, 10, 15, 20, 25, 40};

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_sum", 64'(sum), 64'd0);
    chk("reset_cout", 64'(cout), 64'd0);
`ifdef ADDER_OVERFLOW_FLAG_EN
    chk("reset_ovf", 64'(ovf), 64'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 7; i++) send(1'b1, N'(xs[i]), N'(i), 1'b0);
    send(1'b1, '1, '0, 1'b1);
    send(1'b1, '1, '1, 1'b1);
    send(1'b1, '0, '0, 1'b0);
    send(1'b1, N'(5), N'(1), 1'b0);
    send(1'b0, '0, '0, 1'b0);
    send(1'b1, N'(40), N'(6), 1'b0);
    send(1'b1, N'(127), N'(1), 1'b0);
    send(1'b1, N'(200), N'(100), 1'b0);
    drain();
    for (int i = 0; i < 3; i++) send(1'b1, rnd(), rnd(), 1'($urandom()));
    send(1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_sum", 64'(sum), 64'd0);
    chk("midreset_cout", 64'(cout), 64'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (STAGES + 4) send(1'b0, '0, '0, 1'b0);
    send(1'b1, '1, '0, 1'b1);
    drain();
    for (int i = 0; i < 400; i++) send($urandom_range(0, 3) != 0, rnd(), rnd(), 1'($urandom()));
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/pipelined_nbit_adder.md
Name: pipelined_nbit_adder

Overview:
- Synchronous N-bit binary adder with carry-in and carry-out: sum/cout = a + b + ci.
- Carry chain split into STAGES ripple segments, one register stage each, so wide adders close timing.
- Fully pipelined: one new operand set accepted per clock, no backpressure.
- Used as the arithmetic leaf under datapath/top-level modules; callers instantiate it by port name.

Parameters:
- N, 8, operand and sum width in bits; legal 1..64.
- STAGES, 1, number of pipeline/carry segments; legal 1..N; latency equals STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  a, b, ci are sampled this cycle.
- a  input  N  unsigned operand A.
- b  input  N  unsigned operand B.
- ci  input  1  carry-in.
- out_valid  output  1  sum/cout carry a result this cycle.
- sum  output  N  low N bits of a+b+ci.
- cout  output  1  bit N of a+b+ci.

Behaviour:
- Arithmetic: {cout,sum} = a + b + ci, computed at N+1 bits. No truncation except the defined split into sum and cout.
- Segmenting: segment width W = ceil(N/STAGES); segment k covers bits [k*W, min((k+1)*W, N)-1]. The last segment may be narrower.
- Stage k adds segment k of a and b with the carry registered from stage k-1. Stage 0 uses ci.
- Operand segments not yet consumed are delay-registered alongside the data. Completed low sum segments are delay-registered forward so all bits of one result emerge together.
- Latency: exactly STAGES cycles from the in_valid sample edge to out_valid=1 with the matching sum/cout.
- STAGES=1 is a single registered adder with 1-cycle latency.
- Throughput: one result per cycle. Back-to-back inputs give back-to-back outputs in order.
- in_valid=0: a bubble propagates. out_valid=0 for that slot; sum/cout hold their previous values (do not update on bubbles).
- Reset (asynchronous assert, synchronous deassert at the next clk edge):
  - out_valid=0, sum=0, cout=0.
  - All pipeline, carry and delay registers cleared.
- Reset mid-operation discards every in-flight result. The first valid output after reset comes from an input sampled after deassertion.
- Boundaries:
  - all-ones + all-ones + 1 -> sum = all-ones, cout=1.
  - all-ones + 0 + 1 -> sum=0, cout=1 (carry must propagate through every segment).
  - 0+0+0 -> sum=0, cout=0.
- X on a/b/ci while in_valid=0 must not corrupt valid results.

Optional Feature:
- Macro ADDER_OVERFLOW_FLAG_EN.
- Defined: adds output port ovf (1 bit). It is the two's-complement signed overflow of the same operation, equal to (carry into bit N-1) XOR cout.
  - ovf is aligned with sum, i.e. same latency and same out_valid qualification.
  - ovf resets to 0 and holds on bubbles, like sum.
- Not defined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- N=8, STAGES=1. Sequence (ci,x,y) = (0,0,0), (0,5,1), (0,10,2), (0,15,3), (0,20,4), (0,25,5), (0,40,6), one per cycle -> sums 0, 6, 12, 18, 24, 30, 46, all cout=0, each 1 cycle later with out_valid=1.
- N=8, STAGES=4, same sequence back-to-back -> identical results, each exactly 4 cycles after input, no gaps.
- Carry ripple: a=255, b=0, ci=1 -> sum=0, cout=1. a=255, b=255, ci=1 -> sum=255, cout=1. Run with STAGES=1, 3, 8.
- Bubbles: valid, idle, valid with 5+1 then 40+6 -> out_valid pattern 1,0,1. sum holds 6 during the bubble, then 46.
- Reset mid-stream: STAGES=4, assert rst 2 cycles after issuing 3 operands -> out_valid, sum and cout go 0 immediately. No stale result appears after deassertion.
- With ADDER_OVERFLOW_FLAG_EN: a=127, b=1, ci=0 -> sum=128, cout=0, ovf=1. a=200, b=100 -> sum=44, cout=1, ovf=0.
